// File: rtl/acs_metric_unit.sv
// acs_metric_unit
//   Registered add-compare-select stage for a hard-decision Viterbi decoder
//   (rate-1/2 code, NS = 2^(K-1) trellis states). One trellis step is taken
//   per accepted received symbol pair.
//
//   Optional feature macro: ACS_NORM_EN
//     defined   : metric normalisation (subtract 2^(PM_W-1) when all are high)
//     undefined : metric saturation at 2^PM_W-1
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        frame start, reload initial metrics
//   i_valid        i_rx_sym valid, perform one trellis step
//   i_rx_sym[1:0]  received hard bits {c1,c0}
//   o_valid        one-cycle strobe, step result valid
//   o_decision     survivor bit per next-state (bit n = state n)
//   o_best_state   index of the minimum registered path metric
//   o_best_metric  value of that minimum metric
module acs_metric_unit #(
  parameter int unsigned    K    = 3,
  parameter logic [K-1:0]   G0   = 3'b111,
  parameter logic [K-1:0]   G1   = 3'b101,
  parameter int unsigned    PM_W = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_valid,
  input  logic [1:0]                    i_rx_sym,
  output logic                          o_valid,
  output logic [(2**(K-1))-1:0]         o_decision,
  output logic [K-2:0]                  o_best_state,
  output logic [PM_W-1:0]               o_best_metric
);

  localparam int unsigned NS   = 2 ** (K - 1);
  localparam int unsigned NS_W = K - 1;
  localparam logic [PM_W-1:0] INIT = {1'b0, {(PM_W-1){1'b1}}};
`ifdef ACS_NORM_EN
  localparam logic [PM_W:0] HALF = (PM_W+1)'(1) << (PM_W - 1);
`else
  localparam logic [PM_W:0] MAXV = {1'b0, {PM_W{1'b1}}};
`endif

  logic [PM_W-1:0] pm_q [NS];
  logic [PM_W-1:0] pm_d [NS];
  logic [NS-1:0]   decision_q, decision_d;
  logic            valid_q, valid_d;

  logic [PM_W-1:0] base_pm [NS];
  logic [PM_W:0]   win     [NS];
  logic [NS-1:0]   dec_step;
  logic [NS_W-1:0] ns_idx, pred0, pred1;
  logic            u_bit;
  logic [PM_W:0]   cand0, cand1;
`ifdef ACS_NORM_EN
  logic            all_hi;
`endif
  logic [NS_W-1:0] best_state;
  logic [PM_W-1:0] best_metric;

  // Candidate metric for predecessor s taking input u, at PM_W+1 bits.
  function automatic logic [PM_W:0] cand(input logic [PM_W-1:0] pm,
                                         input logic [NS_W-1:0] s,
                                         input logic            u,
                                         input logic [1:0]      rx);
    logic [K-1:0] r;
    logic [1:0]   d;
    r = {u, s};
    d = {^(r & G1), ^(r & G0)} ^ rx;
    return {1'b0, pm} + (PM_W+1)'(d[0]) + (PM_W+1)'(d[1]);
  endfunction

  // A start in the same cycle as a step makes the step use the initial metrics.
  always_comb begin
    for (int unsigned n = 0; n < NS; n++) begin
      base_pm[n] = i_start ? ((n == 0) ? '0 : INIT) : pm_q[n];
    end
  end

  always_comb begin
    ns_idx   = '0;
    pred0    = '0;
    pred1    = '0;
    u_bit    = 1'b0;
    cand0    = '0;
    cand1    = '0;
    dec_step = '0;
    for (int unsigned n = 0; n < NS; n++) begin
      win[n] = '0;
    end
    for (int unsigned n = 0; n < NS; n++) begin
      ns_idx      = NS_W'(n);
      u_bit       = ns_idx[NS_W-1];
      pred0       = {ns_idx[NS_W-2:0], 1'b0};
      pred1       = {ns_idx[NS_W-2:0], 1'b1};
      cand0       = cand(base_pm[pred0], pred0, u_bit, i_rx_sym);
      cand1       = cand(base_pm[pred1], pred1, u_bit, i_rx_sym);
      dec_step[n] = (cand1 < cand0);
      win[n]      = dec_step[n] ? cand1 : cand0;
    end
  end

  always_comb begin
    valid_d    = i_valid;
    decision_d = decision_q;
    pm_d       = pm_q;
`ifdef ACS_NORM_EN
    all_hi = 1'b1;
    for (int unsigned n = 0; n < NS; n++) begin
      if (win[n] < HALF) all_hi = 1'b0;
    end
`endif
    if (i_valid) begin
      decision_d = dec_step;
      for (int unsigned n = 0; n < NS; n++) begin
`ifdef ACS_NORM_EN
        pm_d[n] = all_hi ? PM_W'(win[n] - HALF) : PM_W'(win[n]);
`else
        pm_d[n] = (win[n] > MAXV) ? MAXV[PM_W-1:0] : win[n][PM_W-1:0];
`endif
      end
    end else if (i_start) begin
      pm_d = base_pm;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned n = 0; n < NS; n++) begin
        pm_q[n] <= (n == 0) ? '0 : INIT;
      end
      decision_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pm_q       <= pm_d;
      decision_q <= decision_d;
      valid_q    <= valid_d;
    end
  end

  // Strict compare keeps the lowest index on equal metrics.
  always_comb begin
    best_state  = '0;
    best_metric = pm_q[0];
    for (int unsigned n = 1; n < NS; n++) begin
      if (pm_q[n] < best_metric) begin
        best_metric = pm_q[n];
        best_state  = NS_W'(n);
      end
    end
  end

  assign o_valid       = valid_q;
  assign o_decision    = decision_q;
  assign o_best_state  = best_state;
  assign o_best_metric = best_metric;

endmodule

// File: tb/tb_acs_metric_unit.sv
module tb_acs_metric_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic       i_valid;
  logic [1:0] i_rx_sym;
  logic       o_valid;
  logic [3:0] o_decision;
  logic [1:0] o_best_state;
  logic [3:0] o_best_metric;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: trellis metrics as plain integers.
  int         pm_m [4];
  logic [3:0] dec_m;
  logic       vld_m;

  always #5 clk = ~clk;

  acs_metric_unit #(
    .K    (3),
    .G0   (3'b111),
    .G1   (3'b101),
    .PM_W (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (i_start),
    .i_valid       (i_valid),
    .i_rx_sym      (i_rx_sym),
    .o_valid       (o_valid),
    .o_decision    (o_decision),
    .o_best_state  (o_best_state),
    .o_best_metric (o_best_metric)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Encoder output {c1,c0} when leaving state s with input u.
  function automatic logic [1:0] code_bits(input int s, input int u);
    int word;
    word = (u << 2) | s;
    return {1'($countones(word & 5) % 2), 1'($countones(word & 7) % 2)};
  endfunction

  function automatic int bm(input int s, input int u, input logic [1:0] r);
    return $countones(code_bits(s, u) ^ r);
  endfunction

  function automatic void model_reset();
    pm_m  = '{0, 7, 7, 7};
    dec_m = '0;
    vld_m = 1'b0;
  endfunction

  // Forward trellis walk: every (state, input) pair feeds its successor.
  function automatic void model_cycle(input bit st, input bit vl, input logic [1:0] r);
    int base [4];
    int nw   [4];
    int nxt, c;
    bit all_hi;
    base = pm_m;
    if (st) base = '{0, 7, 7, 7};
    if (vl) begin
      for (int n = 0; n < 4; n++) nw[n] = 1 << 30;
      for (int s = 0; s < 4; s++) begin
        for (int u = 0; u < 2; u++) begin
          nxt = (u << 1) | (s >> 1);
          c   = base[s] + bm(s, u, r);
          if (c < nw[nxt]) begin
            nw[nxt]    = c;
            dec_m[nxt] = (s % 2 == 1);
          end
        end
      end
`ifdef ACS_NORM_EN
      all_hi = 1'b1;
      for (int n = 0; n < 4; n++) if (nw[n] < 8) all_hi = 1'b0;
      if (all_hi) for (int n = 0; n < 4; n++) nw[n] -= 8;
`else
      all_hi = 1'b0;
      for (int n = 0; n < 4; n++) if (nw[n] > 15) nw[n] = 15;
`endif
      pm_m  = nw;
      vld_m = 1'b1;
    end else begin
      pm_m  = base;
      vld_m = 1'b0;
    end
  endfunction

  function automatic logic [15:0] dut_pm();
    return {dut.pm_q[3], dut.pm_q[2], dut.pm_q[1], dut.pm_q[0]};
  endfunction

  function automatic logic [26:0] got_vec();
    return {o_valid, o_decision, o_best_state, o_best_metric, dut_pm()};
  endfunction

  function automatic logic [26:0] exp_vec();
    int b;
    b = 0;
    for (int n = 1; n < 4; n++) if (pm_m[n] < pm_m[b]) b = n;
    return {vld_m, dec_m, 2'(b), 4'(pm_m[b]),
            4'(pm_m[3]), 4'(pm_m[2]), 4'(pm_m[1]), 4'(pm_m[0])};
  endfunction

  task automatic cycle(input bit st, input bit vl, input logic [1:0] r);
    @(negedge clk);
    i_start  = st;
    i_valid  = vl;
    i_rx_sym = r;
    model_cycle(st, vl, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_rx_sym = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({o_valid, o_decision, o_best_state, o_best_metric, dut_pm()} !== {1'b0, 4'h0, 2'd0, 4'd0, 16'h7770})
      $display("FAIL reset_state: got %h expected %h",
               {o_valid, o_decision, o_best_state, o_best_metric, dut_pm()}, {1'b0, 4'h0, 2'd0, 4'd0, 16'h7770});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_step();
    cycle(1'b1, 1'b1, 2'b00);
    n_checks++;
    if (dut_pm() !== 16'h8280) begin
      n_fail++; $display("FAIL first_step_pm: got %h expected %h", dut_pm(), 16'h8280);
    end
    n_checks++;
    if ({o_valid, o_decision, o_best_state, o_best_metric} !== {1'b1, 4'b0000, 2'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL first_step_out: got %h expected %h",
               {o_valid, o_decision, o_best_state, o_best_metric}, {1'b1, 4'b0000, 2'd0, 4'd0});
    end
    cycle(1'b0, 1'b0, 2'b00);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL valid_one_cycle: got %b expected 0", o_valid);
    end
  endtask

  task automatic test_zero_run();
    for (int t = 0; t < 16; t++) begin
      cycle(t == 0, 1'b1, 2'b00);
      n_checks++;
      if ({o_valid, dut.pm_q[0], o_best_state, o_decision[0]} !== {1'b1, 4'd0, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL zero_run step %0d: got %h expected %h", t,
                 {o_valid, dut.pm_q[0], o_best_state, o_decision[0]}, {1'b1, 4'd0, 2'd0, 1'b0});
      end
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL zero_run_model step %0d: got %h expected %h", t, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_sequence();
    int         bits [6];
    logic [3:0] decs [6];
    int         enc_st, tb_st;
    logic [1:0] sym;
    logic [5:0] got_bits, want_bits;
    bits   = '{1, 0, 1, 1, 0, 0};
    enc_st = 0;
    for (int t = 0; t < 6; t++) begin
      sym = code_bits(enc_st, bits[t]);
      if (t == 3) sym[0] = ~sym[0];
      enc_st = (bits[t] << 1) | (enc_st >> 1);
      cycle(t == 0, 1'b1, sym);
      decs[t] = o_decision;
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL sequence_model step %0d: got %h expected %h", t, got_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({o_best_state, o_best_metric} !== {2'(enc_st), 4'd1}) begin
      n_fail++;
      $display("FAIL sequence_best: got %h expected %h", {o_best_state, o_best_metric}, {2'(enc_st), 4'd1});
    end
    tb_st = int'(o_best_state);
    for (int t = 5; t >= 0; t--) begin
      got_bits[t]  = (tb_st >= 2);
      want_bits[t] = (bits[t] == 1);
      tb_st        = ((tb_st & 1) << 1) | int'(decs[t][tb_st]);
    end
    n_checks++;
    if (got_bits !== want_bits) begin
      n_fail++; $display("FAIL traceback: got %b expected %b", got_bits, want_bits);
    end
  endtask

  task automatic test_gap_hold();
    logic [26:0] held;
    cycle(1'b1, 1'b1, 2'($urandom_range(0, 3)));
    for (int t = 0; t < 3; t++) cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)));
    held = {1'b0, got_vec()[25:0]};
    for (int t = 0; t < 5; t++) begin
      cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)));
      n_checks++;
      if (got_vec() !== held || got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL gap_hold cycle %0d: got %h expected %h", t, got_vec(), held);
      end
    end
    cycle(1'b1, 1'b0, 2'b11);
    n_checks++;
    if ({o_valid, o_best_state, o_best_metric, dut_pm()} !== {1'b0, 2'd0, 4'd0, 16'h7770}) begin
      n_fail++;
      $display("FAIL start_alone: got %h expected %h",
               {o_valid, o_best_state, o_best_metric, dut_pm()}, {1'b0, 2'd0, 4'd0, 16'h7770});
    end
  endtask

  task automatic test_random();
    bit         st, vl;
    logic [1:0] r;
    cycle(1'b1, 1'b0, 2'b00);
    for (int t = 0; t < 60; t++) begin
      st = ($urandom_range(0, 9) == 0);
      vl = ($urandom_range(0, 3) != 0);
      r  = 2'($urandom_range(0, 3));
      cycle(st, vl, r);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random step %0d: got %h expected %h", t, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_overflow();
    for (int t = 0; t < 20; t++) begin
      cycle(t == 0, 1'b1, 2'b11);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL overflow step %0d: got %h expected %h", t, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b1, 2'b01);
    cycle(1'b0, 1'b1, 2'b10);
    @(negedge clk);
    i_start = 1'b0; i_valid = 1'b1; i_rx_sym = 2'b11;
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", o_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({o_valid, o_decision, o_best_state, o_best_metric, dut_pm()} !== {1'b0, 4'h0, 2'd0, 4'd0, 16'h7770}) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected %h",
               {o_valid, o_decision, o_best_state, o_best_metric, dut_pm()}, {1'b0, 4'h0, 2'd0, 4'd0, 16'h7770});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_held: got %h expected %h", got_vec(), exp_vec());
    end
    @(negedge clk);
    i_valid = 1'b0;
    rst_n   = 1'b1;
    cycle(1'b1, 1'b1, 2'b00);
    n_checks++;
    if ({o_valid, o_decision, o_best_state, o_best_metric, dut_pm()} !== {1'b1, 4'h0, 2'd0, 4'd0, 16'h8280}) begin
      n_fail++;
      $display("FAIL post_reset_step: got %h expected %h",
               {o_valid, o_decision, o_best_state, o_best_metric, dut_pm()}, {1'b1, 4'h0, 2'd0, 4'd0, 16'h8280});
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_zero_run();
    test_sequence();
    test_gap_hold();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
